// File: rtl/rkold_prev_sched_if.sv
// Stream and store-port bundle for rkold_prev_sched.
// slave  : the sequencer side (accepts the save stream, presents the load stream,
//          drives the store ports).
// master : the surroundings (producer, consumer and the rKold_prev store itself).
interface rkold_prev_sched_if #(
    parameter int W  = 256,
    parameter int AW = 11
);
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;

    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_last;
    logic          out_ready;

    logic          mem_write_enable;
    logic [AW-1:0] mem_address;
    logic [W-1:0]  mem_input_data;
    logic [AW-1:0] mem_read_address;
    logic [W-1:0]  mem_output;

    modport slave (
        input  in_valid, in_data, out_ready, mem_output,
        output in_ready, out_valid, out_data, out_last,
               mem_write_enable, mem_address, mem_input_data, mem_read_address
    );

    modport master (
        output in_valid, in_data, out_ready, mem_output,
        input  in_ready, out_valid, out_data, out_last,
               mem_write_enable, mem_address, mem_input_data, mem_read_address
    );
endinterface

// File: rtl/rkold_prev_sched.sv
// rkold_prev_sched: save/load sequencer for the rKold_prev row store.
// Optional feature macro: RKOLD_OVERLAP_EN
//   undefined : only one pass at a time; a simultaneous save+load start keeps the save.
//   defined   : save and load may run together; the load is paced behind wr_ptr.
//
// Both engines use the same two-state machine:
//   state  | meaning
//   IDLE   | no pass in progress, waiting for a start command
//   ACTIVE | pass in progress (save: taking beats; load: fetching/presenting beats)
module rkold_prev_sched #(
    parameter int ELEMENT_WIDTH = 32,
    parameter int NO_OF_UNITS   = 8,
    parameter int MEMORY_HEIGHT = 1000,
    parameter int ADDRESS_WIDTH = $clog2(MEMORY_HEIGHT) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     save_start,
    input  logic [ADDRESS_WIDTH-1:0] save_len,
    input  logic                     load_start,
    input  logic [ADDRESS_WIDTH-1:0] load_len,
    rkold_prev_sched_if.slave        bus,
    output logic                     save_busy,
    output logic                     load_busy,
    output logic                     save_done,
    output logic                     load_done,
    output logic                     cmd_err
);
    localparam int AW = ADDRESS_WIDTH;
    localparam logic [AW-1:0] MAX_LEN = AW'(MEMORY_HEIGHT + 1);
    localparam logic [AW-1:0] ONE     = AW'(1);

    typedef enum logic {IDLE, ACTIVE} eng_t;

    eng_t          save_st, load_st;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW-1:0] save_len_q, load_len_q;

    logic save_len_ok, load_len_ok;
    logic save_acc, load_acc;
    logic save_beat, interlock_ok, fetch, consume;

    assign save_len_ok = (save_len != '0) && (save_len <= MAX_LEN);
    assign load_len_ok = (load_len != '0) && (load_len <= MAX_LEN);

`ifdef RKOLD_OVERLAP_EN
    assign save_acc = save_start && (save_st == IDLE) && save_len_ok;
    assign load_acc = load_start && (load_st == IDLE) && load_len_ok;
`else
    // A load arriving together with a save always loses, even if the save is malformed,
    // so the outcome of a simultaneous pair never depends on the save length.
    assign save_acc = save_start && (save_st == IDLE) && (load_st == IDLE) && save_len_ok;
    assign load_acc = load_start && !save_start && (save_st == IDLE) && (load_st == IDLE)
                      && load_len_ok;
`endif

    assign save_beat    = (save_st == ACTIVE) && bus.in_valid && !rst;
    // A row written at an edge is readable the following cycle, so strict less-than is exact.
    assign interlock_ok = (save_st == IDLE) || (rd_ptr < wr_ptr);
    assign fetch        = (load_st == ACTIVE) && (!bus.out_valid || bus.out_ready)
                          && (rd_ptr < load_len_q) && interlock_ok;
    assign consume      = bus.out_valid && bus.out_ready;

    // Store write port and status flags follow the state directly but are forced low
    // while rst is high, so nothing is written during the reset cycle itself.
    assign bus.in_ready         = (save_st == ACTIVE) && !rst;
    assign bus.mem_write_enable = save_beat;
    assign bus.mem_address      = rst ? '0 : wr_ptr;
    assign bus.mem_input_data   = save_beat ? bus.in_data : '0;
    assign bus.mem_read_address = rst ? '0 : rd_ptr;
    assign save_busy            = (save_st == ACTIVE) && !rst;
    assign load_busy            = (load_st == ACTIVE) && !rst;

    // Save engine: latch the length, then count accepted beats up to save_len-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            save_st    <= IDLE;
            wr_ptr     <= '0;
            save_len_q <= '0;
            save_done  <= 1'b0;
        end else begin
            save_done <= 1'b0;
            if (save_acc) begin
                save_st    <= ACTIVE;
                wr_ptr     <= '0;
                save_len_q <= save_len;
            end else if (save_beat) begin
                wr_ptr <= wr_ptr + ONE;
                if (wr_ptr == save_len_q - ONE) begin
                    save_st   <= IDLE;
                    save_done <= 1'b1;
                end
            end
        end
    end

    // Load engine: one-deep output register refilled whenever it is empty or being drained.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_st       <= IDLE;
            rd_ptr        <= '0;
            load_len_q    <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_last  <= 1'b0;
            load_done     <= 1'b0;
        end else begin
            load_done <= 1'b0;
            if (load_acc) begin
                load_st    <= ACTIVE;
                rd_ptr     <= '0;
                load_len_q <= load_len;
            end else if (fetch) begin
                bus.out_data  <= bus.mem_output;
                bus.out_valid <= 1'b1;
                bus.out_last  <= (rd_ptr == load_len_q - ONE);
                rd_ptr        <= rd_ptr + ONE;
            end else if (consume) begin
                bus.out_valid <= 1'b0;
                bus.out_last  <= 1'b0;
                if (bus.out_last) begin
                    load_st   <= IDLE;
                    load_done <= 1'b1;
                end
            end
        end
    end

    // Command error pulse: any start that was not accepted this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_err <= 1'b0;
        end else begin
            cmd_err <= (save_start && !save_acc) || (load_start && !load_acc);
        end
    end
endmodule

// File: tb/tb_rkold_prev_sched.sv
// Scoreboard bench for rkold_prev_sched: the bench holds the row store, a reference copy
// of what each row should contain, and queues of expected writes and load beats.
module tb_rkold_prev_sched;
    localparam int MH = 1000;
    localparam int AW = $clog2(MH) + 1;
    localparam int W  = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          save_start, load_start;
    logic [AW-1:0] save_len, load_len;
    logic          save_busy, load_busy, save_done, load_done, cmd_err;

    rkold_prev_sched_if #(.W(W), .AW(AW)) bus ();

    rkold_prev_sched #(.MEMORY_HEIGHT(MH)) dut (
        .clk        (clk),
        .rst        (rst),
        .save_start (save_start),
        .save_len   (save_len),
        .load_start (load_start),
        .load_len   (load_len),
        .bus        (bus),
        .save_busy  (save_busy),
        .load_busy  (load_busy),
        .save_done  (save_done),
        .load_done  (load_done),
        .cmd_err    (cmd_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Row store (extra headroom so reads past the last row stay in range).
    logic [W-1:0] store [0:2047];
    assign bus.mem_output = store[bus.mem_read_address];
    always @(posedge clk) if (bus.mem_write_enable) store[bus.mem_address] <= bus.mem_input_data;

    typedef struct packed { logic [AW-1:0] addr; logic [W-1:0] data; } wr_t;
    typedef struct packed { logic [W-1:0] data; logic last; } rd_t;
    wr_t exp_wr[$];
    rd_t exp_rd[$];
    logic [W-1:0] ref_rows [0:2047];
    logic [W-1:0] sdat     [0:2047];

    int tests = 0, fails = 0;
    int n_save_done = 0, n_load_done = 0;
    int last_wr_cyc = -1, save_done_cyc = -1, load_done_cyc = -1, ov_rise_cyc = -1;
    logic prev_ov = 1'b0, stalled = 1'b0;
    logic [W-1:0] stall_data;
    wr_t mwe;
    rd_t mre;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name, input logic [W-1:0] act);
        tests++;
        fails++;
        $display("FAIL %s: got %0h expected nothing", name, act);
    endtask

    // Monitor: pops the scoreboard whenever the DUT writes the store or hands over a beat.
    always @(negedge clk) begin
        if (bus.mem_write_enable) begin
            last_wr_cyc = cyc;
            if (exp_wr.size() == 0) begin
                note_fail("unexpected_write", {bus.mem_address, bus.mem_input_data[15:0]});
            end else begin
                mwe = exp_wr.pop_front();
                chk("wr_addr", bus.mem_address, mwe.addr);
                chk("wr_data", bus.mem_input_data, mwe.data);
            end
        end
        if (stalled && bus.out_valid) chk("stall_hold", bus.out_data, stall_data);
        stalled    = bus.out_valid && !bus.out_ready;
        stall_data = bus.out_data;
        if (bus.out_valid && !prev_ov) ov_rise_cyc = cyc;
        prev_ov = bus.out_valid;
        if (bus.out_valid && bus.out_ready) begin
            if (exp_rd.size() == 0) begin
                note_fail("unexpected_beat", bus.out_data);
            end else begin
                mre = exp_rd.pop_front();
                chk("rd_data", bus.out_data, mre.data);
                chk("rd_last", bus.out_last, mre.last);
            end
        end
        if (save_done) begin n_save_done++; save_done_cyc = cyc; end
        if (load_done) begin n_load_done++; load_done_cyc = cyc; end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_in_ready"}, bus.in_ready, 0);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_out_data"}, bus.out_data, 0);
        chk({tag, "_out_last"}, bus.out_last, 0);
        chk({tag, "_mem_we"}, bus.mem_write_enable, 0);
        chk({tag, "_mem_addr"}, bus.mem_address, 0);
        chk({tag, "_mem_wdata"}, bus.mem_input_data, 0);
        chk({tag, "_mem_raddr"}, bus.mem_read_address, 0);
        chk({tag, "_busy"}, {save_busy, load_busy}, 0);
        chk({tag, "_pulses"}, {save_done, load_done, cmd_err}, 0);
    endtask

    // Expected contents: a save of n rows writes rows 0..n-1 with fresh data.
    task automatic issue_save(input int n, input bit directed);
        wr_t e;
        for (int k = 0; k < n; k++) begin
            sdat[k]     = directed ? W'(32'hA + k) : {8{$urandom}};
            ref_rows[k] = sdat[k];
            e.addr = AW'(k);
            e.data = sdat[k];
            exp_wr.push_back(e);
        end
    endtask

    task automatic issue_load(input int n);
        rd_t e;
        for (int k = 0; k < n; k++) begin
            e.data = ref_rows[k];
            e.last = (k == n - 1);
            exp_rd.push_back(e);
        end
    endtask

    task automatic cmd(input bit s, input int sl, input bit l, input int ll, output int c0);
        save_start = s;
        save_len   = AW'(sl);
        load_start = l;
        load_len   = AW'(ll);
        c0         = cyc;
        @(posedge clk); #1;
        save_start = 1'b0;
        load_start = 1'b0;
    endtask

    // mode 0: valid held, 1: random valid, 2: held with a 3-cycle gap after row 2.
    task automatic save_stream(input int n, input int mode, input int stop);
        int i = 0, gap = 0, guard = 0;
        while (i < n && i < stop && guard < 5000) begin
            if (mode == 1) bus.in_valid = ($urandom_range(0, 3) != 0);
            else if (mode == 2 && gap > 0) begin bus.in_valid = 1'b0; gap--; end
            else bus.in_valid = 1'b1;
            bus.in_data = sdat[i];
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) begin
                i++;
                if (mode == 2 && i == 3) gap = 3;
            end
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 5000) note_fail("save_stream_timeout", i);
        if (i >= n) bus.in_valid = 1'b0;
    endtask

    // mode 0: ready pattern 1,0,1,1,0,1 then high, 1: random ready, 2: ready held high.
    task automatic load_drain(input int mode);
        int start = n_load_done;
        int k = 0;
        bit pat [6] = '{1, 0, 1, 1, 0, 1};
        while (n_load_done == start && k < 3000) begin
            if (mode == 0) bus.out_ready = (k < 6) ? pat[k] : 1'b1;
            else if (mode == 1) bus.out_ready = 1'($urandom_range(0, 1));
            else bus.out_ready = 1'b1;
            @(posedge clk); #1;
            k++;
        end
        bus.out_ready = 1'b0;
        chk("load_done_count", n_load_done, start + 1);
    endtask

    task automatic wait_save(input int target);
        for (int k = 0; k < 3000 && n_save_done < target; k++) @(posedge clk);
        #1;
        chk("save_done_count", n_save_done, target);
    endtask

    initial begin
        int c0, sd, n;
        rst = 1'b1;
        save_start = 1'b0; load_start = 1'b0; save_len = '0; load_len = '0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed save of 4 rows, data 0xA..0xD.
        sd = n_save_done;
        issue_save(4, 1'b1);
        cmd(1, 4, 0, 0, c0);
        save_stream(4, 0, 4);
        wait_save(sd + 1);
        chk("save4_done_cyc", save_done_cyc, c0 + 5);
        chk("save4_last_wr_cyc", last_wr_cyc, c0 + 4);
        chk("save4_all_written", exp_wr.size(), 0);
        @(negedge clk);
        chk("save4_in_ready_after", bus.in_ready, 0);
        @(posedge clk); #1;

        // Directed load of 4 rows with a stalling consumer.
        issue_load(4);
        cmd(0, 0, 1, 4, c0);
        load_drain(0);
        chk("load4_first_valid_cyc", ov_rise_cyc, c0 + 2);
        chk("load4_all_beats", exp_rd.size(), 0);

        // Illegal lengths.
        cmd(1, 0, 0, 0, c0);
        @(negedge clk);
        chk("save_len0_cmd_err", cmd_err, 1);
        chk("save_len0_busy", {save_busy, load_busy}, 0);
        @(posedge clk); #1;
        cmd(0, 0, 1, MH + 2, c0);
        @(negedge clk);
        chk("load_len_big_cmd_err", cmd_err, 1);
        chk("load_len_big_busy", {save_busy, load_busy}, 0);
        @(posedge clk); #1;

        // Maximum length save and load (MEMORY_HEIGHT+1 rows).
        sd = n_save_done;
        issue_save(MH + 1, 1'b0);
        cmd(1, MH + 1, 0, 0, c0);
        save_stream(MH + 1, 0, MH + 1);
        wait_save(sd + 1);
        chk("save_max_done_cyc", save_done_cyc, c0 + MH + 2);
        chk("save_max_all_written", exp_wr.size(), 0);
        issue_load(MH + 1);
        cmd(0, 0, 1, MH + 1, c0);
        load_drain(2);
        chk("load_max_done_cyc", load_done_cyc, c0 + MH + 3);
        chk("load_max_all_beats", exp_rd.size(), 0);

        // Single-row load.
        issue_load(1);
        cmd(0, 0, 1, 1, c0);
        load_drain(2);
        chk("load1_first_valid_cyc", ov_rise_cyc, c0 + 2);
        chk("load1_done_cyc", load_done_cyc, c0 + 3);
        chk("load1_all_beats", exp_rd.size(), 0);

        // Simultaneous save and load starts, 8 rows each, producer gap after row 2.
        sd = n_save_done;
        issue_save(8, 1'b0);
`ifdef RKOLD_OVERLAP_EN
        issue_load(8);
`endif
        cmd(1, 8, 1, 8, c0);
        @(negedge clk);
`ifdef RKOLD_OVERLAP_EN
        chk("sim_cmd_err", cmd_err, 0);
        chk("sim_load_busy", load_busy, 1);
        @(posedge clk); #1;
        fork
            save_stream(8, 2, 8);
            load_drain(1);
        join
        wait_save(sd + 1);
`else
        chk("sim_cmd_err", cmd_err, 1);
        chk("sim_load_busy", load_busy, 0);
        @(posedge clk); #1;
        save_stream(8, 2, 8);
        wait_save(sd + 1);
`endif
        chk("sim_all_written", exp_wr.size(), 0);
        chk("sim_all_beats", exp_rd.size(), 0);

        // Reset in the middle of a 6-row save, after 2 rows.
        sd = n_save_done;
        issue_save(6, 1'b0);
        cmd(1, 6, 0, 0, c0);
        save_stream(6, 0, 2);
        bus.in_data  = sdat[2];
        bus.in_valid = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_mem_we", bus.mem_write_enable, 0);
        chk("rst_mid_in_ready", bus.in_ready, 0);
        chk("rst_mid_save_busy", save_busy, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check_zero("rst_mid");
        chk("rst_mid_rows_taken", exp_wr.size(), 4);
        exp_wr.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mid_no_done", n_save_done, sd);

        sd = n_save_done;
        issue_save(6, 1'b0);
        cmd(1, 6, 0, 0, c0);
        save_stream(6, 0, 6);
        wait_save(sd + 1);
        chk("resave_done_cyc", save_done_cyc, c0 + 7);
        chk("resave_all_written", exp_wr.size(), 0);

        // Randomized save/load round trips.
        for (int it = 0; it < 6; it++) begin
            n  = $urandom_range(1, 12);
            sd = n_save_done;
            issue_save(n, 1'b0);
            cmd(1, n, 0, 0, c0);
            save_stream(n, 1, n);
            wait_save(sd + 1);
            chk("rand_all_written", exp_wr.size(), 0);
            issue_load(n);
            cmd(0, 0, 1, n, c0);
            load_drain(1);
            chk("rand_all_beats", exp_rd.size(), 0);
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
